// File: rtl/proj_pkg.sv
// Shared constants and types for the proj_* min-hash datapath.
// Holds the FM buffer geometry, the writer state encoding and the hash word type.
package proj_pkg;

    localparam int FM_BUFFER_SIZE = 8;
    localparam int DATA_WIDTH     = 32;
    localparam int FM_IDX_W       = $clog2(FM_BUFFER_SIZE);

    typedef enum logic [1:0] {
        FILL,
        PAD,
        HANDOFF,
        WAIT_READ
    } fm_wr_state_t;

    typedef logic [DATA_WIDTH-1:0] fm_word_t;

endpackage

// File: rtl/proj_edge_detect.sv
// Rising-edge detector: keeps a registered copy of d and flags the cycle
// in which d is high while its previous-cycle value was low.
module proj_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d && !d_q;

endmodule

// File: rtl/proj_fm_writer.sv
// Fills the FM buffer from a valid/ready hash stream, pads short batches with
// PAD_VALUE, pulses start_read, then stalls input until the reader completes.
module proj_fm_writer #(
    parameter int                      FM_BUFFER_SIZE = proj_pkg::FM_BUFFER_SIZE,
    parameter int                      DATA_WIDTH     = proj_pkg::DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   PAD_VALUE      = '1,
    localparam int                     IDX_W          = $clog2(FM_BUFFER_SIZE)
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [IDX_W-1:0]      wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  start_read,
    input  logic                  read_done,
    output logic [IDX_W:0]        fill_level,
    output logic [15:0]           batch_count
);

    import proj_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FM_BUFFER_SIZE - 1);

    fm_wr_state_t     state;
    logic [IDX_W-1:0] index;
    logic             accept;
    logic             read_done_rise;

    // The detector samples read_done in every state, so a level that is
    // already high when WAIT_READ is entered never looks like a new edge.
    proj_edge_detect u_done_edge (
        .clk  (in_clk),
        .rst  (in_rst),
        .d    (read_done),
        .rise (read_done_rise)
    );

    assign in_ready = (state == FILL) && !in_rst;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state       <= FILL;
            index       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            start_read  <= 1'b0;
            fill_level  <= '0;
            batch_count <= '0;
        end else begin
            wr_en      <= 1'b0;
            start_read <= 1'b0;
            case (state)
                FILL: begin
                    if (accept) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= index;
                        wr_data    <= in_data;
                        fill_level <= fill_level + 1'b1;
                        if (index == LAST_IDX) begin
                            index <= '0;
                            state <= HANDOFF;
                        end else begin
                            index <= index + 1'b1;
                            if (in_last) begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    wr_en   <= 1'b1;
                    wr_addr <= index;
                    wr_data <= PAD_VALUE;
                    if (index == LAST_IDX) begin
                        index <= '0;
                        state <= HANDOFF;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                HANDOFF: begin
                    start_read <= 1'b1;
                    state      <= WAIT_READ;
                end
                WAIT_READ: begin
                    if (read_done_rise) begin
                        batch_count <= batch_count + 1'b1;
                        fill_level  <= '0;
                        index       <= '0;
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
